fifo_rd_stream: RTL and testbench



---
 rtl/fir_stream_pkg.sv | 16 +
 rtl/fifo_rd_stream_skid2.sv | 56 +++++
 rtl/fifo_rd_stream.sv | 96 +++++++++
 tb/tb_fifo_rd_stream.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_stream_pkg.sv
// Shared definitions for the FIFO-to-FIR sample stream.
package fir_stream_pkg;

    // Default sample width; matches the dual-clock FIFO data width.
    localparam int DSIZE_DEF     = 16;

    // Default samples per frame; one per FIR tap.
    localparam int FRAME_LEN_DEF = 64;

    // Width of the sample-index and frame counters.
    // The FIR control block reuses this width.
    localparam int FRAME_CNT_W   = 16;

    typedef logic [DSIZE_DEF-1:0] sample_t;

endpackage

// File: rtl/fifo_rd_stream_skid2.sv
// Two-entry in-order buffer: push at tail, pop at head, occupancy 0..2.
module stream_skid2
    import fir_stream_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [DSIZE-1:0] i_push_data,
    input  logic             i_pop,
    output logic [DSIZE-1:0] o_head,
    output logic [1:0]       o_occ
);

    logic [DSIZE-1:0] r_head;
    logic [DSIZE-1:0] r_tail;
    logic [1:0]       r_occ;
    logic             w_push;
    logic             w_pop;

    // A full buffer ignores push and an empty one ignores pop.
    // This keeps the occupancy count consistent even with a misbehaving caller.
    assign w_push = i_push & (r_occ != 2'd2);
    assign w_pop  = i_pop  & (r_occ != 2'd0);

    // Entry storage and occupancy; the head always holds the oldest sample.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else begin
            if (w_pop) begin
                // Promote the tail when it exists.
                // Otherwise a simultaneous push lands directly in the head.
                if (r_occ == 2'd2) begin
                    r_head <= r_tail;
                end else if (w_push) begin
                    r_head <= i_push_data;
                end
            end else if (w_push) begin
                if (r_occ == 2'd0) begin
                    r_head <= i_push_data;
                end else begin
                    r_tail <= i_push_data;
                end
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_head = r_head;
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: pops show-ahead FIFO samples into a 2-entry skid
// buffer and presents them as a valid/ready stream.
// The stream carries frame tagging and a sticky mid-frame starvation flag.
module fifo_rd_stream
    import fir_stream_pkg::*;
#(
    parameter int DSIZE     = DSIZE_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CNTW      = FRAME_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_starve,
    input  logic [DSIZE-1:0] fifo_rdata,
    input  logic             fifo_rempty,
    output logic             fifo_rinc,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [CNTW-1:0]  sample_idx,
    output logic [CNTW-1:0]  frame_cnt,
    output logic             starve
);

    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(FRAME_LEN - 1);

    logic [1:0]      w_occ;
    logic            w_rinc;
    logic            w_valid;
    logic            w_accept;
    logic            w_last;
    logic            w_starve_set;
    logic [CNTW-1:0] r_idx;
    logic [CNTW-1:0] r_frames;
    logic            r_starve;

    // The pop decision uses only registered state (occupancy, FIFO empty).
    // Downstream ready therefore never reaches the FIFO read pointer
    // combinationally. Pops are held off while reset is asserted.
    assign w_rinc       = ~rst & en & ~fifo_rempty & (w_occ != 2'd2);
    assign w_valid      = (w_occ != 2'd0);
    assign w_accept     = w_valid & m_ready;
    assign w_last       = w_valid & (r_idx == LAST_IDX);

    // Running dry at a frame boundary is fine.
    // Only an empty buffer part-way through a frame counts as starvation.
    assign w_starve_set = en & (w_occ == 2'd0) & fifo_rempty & (r_idx != '0);

    stream_skid2 #(
        .DSIZE (DSIZE)
    ) u_skid (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_push      (w_rinc),
        .i_push_data (fifo_rdata),
        .i_pop       (w_accept),
        .o_head      (m_data),
        .o_occ       (w_occ)
    );

    // Sample index within the frame and completed-frame count advance on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_frames <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_idx    <= '0;
                r_frames <= r_frames + CNTW'(1);
            end else begin
                r_idx    <= r_idx + CNTW'(1);
            end
        end
    end

    // Sticky starvation flag; a new starvation event wins over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= 1'b0;
        end else if (w_starve_set) begin
            r_starve <= 1'b1;
        end else if (clr_starve) begin
            r_starve <= 1'b0;
        end
    end

    assign fifo_rinc  = w_rinc;
    assign m_valid    = w_valid;
    assign m_last     = w_last;
    assign sample_idx = r_idx;
    assign frame_cnt  = r_frames;
    assign starve     = r_starve;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: directed scenarios plus a randomized phase.
// Results are compared with a count-based behavioural model of the stream.
module tb_fifo_rd_stream;

    localparam int DSIZE = 16;
    localparam int FL    = 4;
    localparam int CNTW  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             clr_starve;
    logic [DSIZE-1:0] fifo_rdata;
    logic             fifo_rempty;
    logic             fifo_rinc;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic [CNTW-1:0]  sample_idx;
    logic [CNTW-1:0]  frame_cnt;
    logic             starve;

    // Show-ahead FIFO model: ring of samples with write/read counters.
    logic [DSIZE-1:0] mem [0:1023];
    int               wp = 0;
    int               rp = 0;

    // Scoreboard and abstract stream state.
    logic [DSIZE-1:0] exp_q [$];
    int               occ_m = 0;
    int               acc_m = 0;
    bit               st_m  = 1'b0;
    bit               e_rinc, e_valid, e_acc;
    bit               mon_en = 1'b0;

    int               n_chk  = 0;
    int               n_pass = 0;

    always #5 clk = ~clk;

    assign fifo_rempty = (rp == wp);
    assign fifo_rdata  = mem[rp % 1024];

    always @(posedge clk) if (fifo_rinc === 1'b1) rp <= rp + 1;

    fifo_rd_stream #(
        .DSIZE     (DSIZE),
        .FRAME_LEN (FL),
        .CNTW      (CNTW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .clr_starve  (clr_starve),
        .fifo_rdata  (fifo_rdata),
        .fifo_rempty (fifo_rempty),
        .fifo_rinc   (fifo_rinc),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .sample_idx  (sample_idx),
        .frame_cnt   (frame_cnt),
        .starve      (starve)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [DSIZE-1:0] v);
        mem[wp % 1024] = v;
        wp = wp + 1;
        exp_q.push_back(v);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; m_ready = 1'b0; clr_starve = 1'b0;
        adv();
        adv();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            adv();
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    // Stream model, evaluated mid-cycle when all inputs are stable.
    // Occupancy is simply pops minus accepts since reset.
    // Frame position is the accept count modulo the frame length.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                occ_m = 0;
                acc_m = 0;
                st_m  = 1'b0;
                exp_q.delete();
                for (int i = rp; i < wp; i++) exp_q.push_back(mem[i % 1024]);
            end else begin
                e_valid = (occ_m != 0);
                e_rinc  = en && !fifo_rempty && (occ_m < 2);
                e_acc   = e_valid && m_ready;
                chk("m_valid", m_valid, e_valid);
                chk("fifo_rinc", fifo_rinc, e_rinc);
                chk("starve", starve, st_m);
                chk("sample_idx", sample_idx, acc_m % FL);
                chk("frame_cnt", frame_cnt, (acc_m / FL) % 65536);
                chk("m_last", m_last, e_valid && ((acc_m % FL) == FL - 1));
                if (e_acc) begin
                    if (exp_q.size() == 0) chk("sample_available", exp_q.size(), 1);
                    else chk("m_data", m_data, exp_q.pop_front());
                end
                if (en && occ_m == 0 && fifo_rempty && (acc_m % FL) != 0) st_m = 1'b1;
                else if (clr_starve) st_m = 1'b0;
                occ_m = occ_m + int'(e_rinc) - int'(e_acc);
                acc_m = acc_m + int'(e_acc);
            end
        end
    end

    initial begin
        int pops;
        int nacc;

        rst = 1'b1; en = 1'b0; m_ready = 1'b0; clr_starve = 1'b0;
        mon_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_rinc", fifo_rinc, 0);
        chk("rst_idx", sample_idx, 0);
        chk("rst_frames", frame_cnt, 0);
        chk("rst_starve", starve, 0);
        adv();
        adv();
        rst = 1'b0;

        // Preloaded FIFO streams out at one sample per cycle
        en = 1'b1; m_ready = 1'b1;
        for (int v = 1; v <= 4; v++) push(DSIZE'(v));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t1_rinc", fifo_rinc, k < 4);
            chk("t1_valid", m_valid, k >= 1 && k <= 4);
            if (k >= 1 && k <= 4) chk("t1_data", m_data, k);
            adv();
        end

        // Backpressure: only two pops, head held, then all ten emerge in order
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(DSIZE'(16'h0100 + i));
        pops = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            pops += int'(fifo_rinc);
            if (k >= 1) chk("t2_hold_data", m_data, 16'h0100);
            adv();
        end
        chk("t2_pop_count", pops, 2);
        @(negedge clk);
        chk("t2_rinc_full", fifo_rinc, 0);
        chk("t2_valid_full", m_valid, 1);
        adv();
        m_ready = 1'b1;
        drain("t2_drained", 40);
        @(negedge clk);
        chk("t2_valid_empty", m_valid, 0);
        adv();
        do_reset();

        // Framing: m_last on samples 4 and 8, two frames, ninth sample at index 0
        en = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 9; i++) push(DSIZE'(16'h0200 + i));
        nacc = 0;
        for (int k = 0; k < 30 && nacc < 9; k++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                nacc++;
                chk("t3_last", m_last, nacc == 4 || nacc == 8);
                if (nacc == 5) chk("t3_frame1", frame_cnt, 1);
                if (nacc == 9) begin
                    chk("t3_idx9", sample_idx, 0);
                    chk("t3_frames", frame_cnt, 2);
                end
            end
            adv();
        end
        chk("t3_count", nacc, 9);
        do_reset();

        // Starvation mid-frame, set-over-clear priority, clear, boundary case
        en = 1'b1; m_ready = 1'b1;
        push(16'h0300);
        push(16'h0301);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_pre_starve", starve, 0);
            if (k == 3) chk("t4_buffer_empty", m_valid, 0);
            adv();
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_starve_set", starve, 1);
            adv();
        end
        clr_starve = 1'b1;
        adv();
        clr_starve = 1'b0;
        @(negedge clk);
        chk("t4_set_priority", starve, 1);
        adv();
        en = 1'b0;
        clr_starve = 1'b1;
        adv();
        clr_starve = 1'b0;
        @(negedge clk);
        chk("t4_cleared", starve, 0);
        adv();
        @(negedge clk);
        chk("t4_stays_clear", starve, 0);
        adv();
        en = 1'b1;
        push(16'h0302);
        push(16'h0303);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t4_boundary_no_starve", starve, 0);
            adv();
        end
        chk("t4_boundary_frames", frame_cnt, 1);
        chk("t4_boundary_idx", sample_idx, 0);
        do_reset();

        // en toggle: buffered samples drain without pops, then pops resume
        en = 1'b1; m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(DSIZE'(16'h0400 + i));
        adv();
        adv();
        adv();
        en = 1'b0; m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5_rinc_off", fifo_rinc, 0);
            chk("t5_valid", m_valid, k < 2);
            adv();
        end
        en = 1'b1;
        @(negedge clk);
        chk("t5_resume_rinc", fifo_rinc, 1);
        adv();
        @(negedge clk);
        chk("t5_resume_valid", m_valid, 1);
        chk("t5_resume_data", m_data, 16'h0402);
        adv();
        drain("t5_drained", 20);
        do_reset();

        // Reset with two buffered samples at sample_idx 3
        en = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 3; i++) push(DSIZE'(16'h0500 + i));
        drain("t6_first_drain", 20);
        adv();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(DSIZE'(16'h0510 + i));
        adv();
        adv();
        @(negedge clk);
        chk("t6_pre_valid", m_valid, 1);
        chk("t6_pre_idx", sample_idx, 3);
        chk("t6_pre_starve", starve, 1);
        chk("t6_pre_data", m_data, 16'h0510);
        adv();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rinc_in_rst", fifo_rinc, 0);
        adv();
        @(negedge clk);
        chk("t6_valid", m_valid, 0);
        chk("t6_idx", sample_idx, 0);
        chk("t6_frames", frame_cnt, 0);
        chk("t6_starve", starve, 0);
        chk("t6_rinc", fifo_rinc, 0);
        chk("t6_last", m_last, 0);
        adv();
        rst = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        chk("t6_resume_rinc", fifo_rinc, 1);
        adv();
        @(negedge clk);
        chk("t6_resume_data", m_data, 16'h0512);
        adv();
        drain("t6_drained", 20);
        do_reset();

        // Randomized traffic checked entirely by the stream model
        for (int k = 0; k < 500; k++) begin
            en         = ($urandom_range(0, 9) != 0);
            m_ready    = ($urandom_range(0, 3) != 0);
            clr_starve = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 2) != 0) push(DSIZE'($urandom));
            if ($urandom_range(0, 7) == 0) push(DSIZE'($urandom));
            adv();
        end
        en = 1'b1; m_ready = 1'b1; clr_starve = 1'b0;
        drain("t7_drained", 1200);
        adv();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
